// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - write-side front end: clear sweep, writeback FIFO, forwarding
module regfile_write_port #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AW-1:0]                in_addr,
  input  logic [DW-1:0]                in_data,
  input  logic                         wr_stall,
  output logic                         wr_en,
  output logic [AW-1:0]                wr_addr,
  output logic [DW-1:0]                wr_data,
  input  logic [AW-1:0]                rA,
  input  logic [AW-1:0]                rB,
  output logic                         fwd_a_hit,
  output logic [DW-1:0]                fwd_a_data,
  output logic                         fwd_b_hit,
  output logic [DW-1:0]                fwd_b_data,
  output logic                         init_done,
  output logic [$clog2(DEPTH):0]       pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [AW-1:0] clr_cnt;
  logic          clr_last;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          running;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  // The clear sweep ends on the edge that writes the last register address.
  assign clr_last   = &clr_cnt;
  assign running    = (state == ST_RUN) && !reset;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);

  // Head presented to the write port reads as zero when nothing is queued.
  assign head_addr  = fifo_empty ? '0 : mem_addr[rd_ptr];
  assign head_data  = fifo_empty ? '0 : mem_data[rd_ptr];

  // No push-through when full: in_ready depends only on the registered count.
  assign push = running && in_valid && !fifo_full;
  assign pop  = running && !fifo_empty && !wr_stall;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and write-port / handshake outputs, reset forces everything idle.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    in_ready   = 1'b0;
    init_done  = 1'b0;
    pending    = '0;
    if (!reset) begin
      case (state)
        ST_INIT: begin
          wr_en   = 1'b1;
          wr_addr = clr_cnt;
          wr_data = '0;
          if (clr_last) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          init_done = 1'b1;
          in_ready  = !fifo_full;
          wr_en     = pop;
          wr_addr   = head_addr;
          wr_data   = head_data;
          pending   = count;
        end
        default: begin
          state_next = ST_INIT;
        end
      endcase
    end
  end

  // Clear-sweep address counter; only advances while in INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
    end else if (state == ST_INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  // FIFO storage: entries are written at the write pointer on accept.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; reset discards any queued writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Forwarding search walks oldest to youngest so the youngest match wins;
  // the head being written this cycle is still a valid source.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_a_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_hit  = 1'b0;
    fwd_b_data = '0;
    idx        = '0;
    if (running) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if (CW'(i) < count) begin
          if (mem_addr[idx] == rA) begin
            fwd_a_hit  = 1'b1;
            fwd_a_data = mem_data[idx];
          end
          if (mem_addr[idx] == rB) begin
            fwd_b_hit  = 1'b1;
            fwd_b_data = mem_data[idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// tb/tb_regfile_write_port.sv - table-driven and scoreboard bench for regfile_write_port
module tb_regfile_write_port;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NREG  = 1 << AW;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          wr_stall;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rA;
  logic [AW-1:0] rB;
  logic          fwd_a_hit;
  logic [DW-1:0] fwd_a_data;
  logic          fwd_b_hit;
  logic [DW-1:0] fwd_b_data;
  logic          init_done;
  logic [$clog2(DEPTH):0] pending;

  regfile_write_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .wr_stall   (wr_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rA         (rA),
    .rB         (rB),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_b_data (fwd_b_data),
    .init_done  (init_done),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  typedef struct {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          stall;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    int            e_pending;
    logic          e_ready;
    logic          e_wr_en;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_ahit;
    logic [DW-1:0] e_adata;
    logic          e_bhit;
    logic [DW-1:0] e_bdata;
  } vec_t;

  wb_t  sb[$];
  vec_t vecs[12];
  int   checks;
  int   errors;
  logic running;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare for the current cycle, then advance one clock.
  task automatic step();
    logic          exp_ready;
    logic          exp_we;
    logic          ah;
    logic          bh;
    logic [DW-1:0] ad;
    logic [DW-1:0] bd;
    if (running) begin
      exp_ready = (sb.size() != DEPTH);
      exp_we    = (sb.size() != 0) && !wr_stall;
      chk("sb_pending", 32'(pending), 32'(sb.size()));
      chk("sb_in_ready", 32'(in_ready), 32'(exp_ready));
      chk("sb_wr_en", 32'(wr_en), 32'(exp_we));
      ah = 1'b0; bh = 1'b0; ad = '0; bd = '0;
      foreach (sb[i]) begin
        if (sb[i].addr == rA) begin ah = 1'b1; ad = sb[i].data; end
        if (sb[i].addr == rB) begin bh = 1'b1; bd = sb[i].data; end
      end
      chk("sb_fwd_a_hit", 32'(fwd_a_hit), 32'(ah));
      chk("sb_fwd_a_data", 32'(fwd_a_data), 32'(ad));
      chk("sb_fwd_b_hit", 32'(fwd_b_hit), 32'(bh));
      chk("sb_fwd_b_data", 32'(fwd_b_data), 32'(bd));
      if (exp_we) begin
        chk("sb_wr_addr", 32'(wr_addr), 32'(sb[0].addr));
        chk("sb_wr_data", 32'(wr_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end
      if (in_valid && exp_ready) begin
        sb.push_back('{addr: in_addr, data: in_data});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_fwd_a_hit", 32'(fwd_a_hit), 0);
    chk("rst_fwd_b_data", 32'(fwd_b_data), 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_init_sweep();
    for (int i = 0; i < NREG; i++) begin
      #1;
      chk("init_wr_en", 32'(wr_en), 1);
      chk("init_wr_addr", 32'(wr_addr), 32'(i));
      chk("init_wr_data", 32'(wr_data), 0);
      chk("init_in_ready", 32'(in_ready), 0);
      chk("init_done_low", 32'(init_done), 0);
      chk("init_pending", 32'(pending), 0);
      chk("init_fwd_a_hit", 32'(fwd_a_hit), 0);
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("init_done_high", 32'(init_done), 1);
    chk("post_init_wr_en", 32'(wr_en), 0);
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic s, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    in_valid = v; in_addr = a; in_data = d; wr_stall = s; rA = ra; rB = rb;
  endtask

  initial begin
    checks = 0; errors = 0; running = 1'b0;
    reset = 1'b1;
    drive(1'b1, 5'd4, 8'hEE, 1'b0, 5'd4, 5'd0);

    //           v  addr  data  st  rA  rB  pend rdy we waddr wdata ah ad    bh bd
    vecs[0]  = '{1, 5'd5, 8'hA5, 0, 5'd5, 5'd0, 0, 1, 0, 5'd0, 8'h00, 0, 8'h00, 0, 8'h00};
    vecs[1]  = '{0, 5'd0, 8'h00, 0, 5'd5, 5'd0, 1, 1, 1, 5'd5, 8'hA5, 1, 8'hA5, 0, 8'h00};
    vecs[2]  = '{1, 5'd3, 8'h11, 1, 5'd3, 5'd8, 0, 1, 0, 5'd0, 8'h00, 0, 8'h00, 0, 8'h00};
    vecs[3]  = '{1, 5'd7, 8'h22, 1, 5'd3, 5'd8, 1, 1, 0, 5'd0, 8'h00, 1, 8'h11, 0, 8'h00};
    vecs[4]  = '{1, 5'd3, 8'h33, 1, 5'd3, 5'd8, 2, 1, 0, 5'd0, 8'h00, 1, 8'h11, 0, 8'h00};
    vecs[5]  = '{1, 5'd9, 8'h44, 1, 5'd3, 5'd8, 3, 1, 0, 5'd0, 8'h00, 1, 8'h33, 0, 8'h00};
    vecs[6]  = '{1, 5'd1, 8'h55, 1, 5'd3, 5'd8, 4, 0, 0, 5'd0, 8'h00, 1, 8'h33, 0, 8'h00};
    vecs[7]  = '{1, 5'd1, 8'h55, 0, 5'd3, 5'd9, 4, 0, 1, 5'd3, 8'h11, 1, 8'h33, 1, 8'h44};
    vecs[8]  = '{0, 5'd0, 8'h00, 0, 5'd3, 5'd9, 3, 1, 1, 5'd7, 8'h22, 1, 8'h33, 1, 8'h44};
    vecs[9]  = '{0, 5'd0, 8'h00, 0, 5'd3, 5'd9, 2, 1, 1, 5'd3, 8'h33, 1, 8'h33, 1, 8'h44};
    vecs[10] = '{0, 5'd0, 8'h00, 0, 5'd3, 5'd9, 1, 1, 1, 5'd9, 8'h44, 0, 8'h00, 1, 8'h44};
    vecs[11] = '{0, 5'd0, 8'h00, 0, 5'd3, 5'd9, 0, 1, 0, 5'd0, 8'h00, 0, 8'h00, 0, 8'h00};

    @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_outputs();
    reset = 1'b0;
    drive(1'b0, 5'd0, 8'h00, 1'b1, 5'd0, 5'd0);
    check_init_sweep();
    running = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].ra, vecs[i].rb);
      #1;
      chk("tbl_pending", 32'(pending), 32'(vecs[i].e_pending));
      chk("tbl_in_ready", 32'(in_ready), 32'(vecs[i].e_ready));
      chk("tbl_wr_en", 32'(wr_en), 32'(vecs[i].e_wr_en));
      if (vecs[i].e_wr_en) begin
        chk("tbl_wr_addr", 32'(wr_addr), 32'(vecs[i].e_waddr));
        chk("tbl_wr_data", 32'(wr_data), 32'(vecs[i].e_wdata));
      end
      chk("tbl_fwd_a_hit", 32'(fwd_a_hit), 32'(vecs[i].e_ahit));
      chk("tbl_fwd_a_data", 32'(fwd_a_data), 32'(vecs[i].e_adata));
      chk("tbl_fwd_b_hit", 32'(fwd_b_hit), 32'(vecs[i].e_bhit));
      chk("tbl_fwd_b_data", 32'(fwd_b_data), 32'(vecs[i].e_bdata));
      step();
    end

    // Steady stream: one accept and one write per cycle, occupancy settles at 1.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 5'($urandom_range(0, NREG - 1)), 8'($urandom), 1'b0,
            5'($urandom_range(0, NREG - 1)), 5'($urandom_range(0, NREG - 1)));
      #1;
      if (i > 0) chk("stream_pending", 32'(pending), 1);
      step();
    end
    drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 5'd0);
    #1;
    step();
    #1;
    chk("stream_drained", 32'(pending), 0);
    step();

    // Reset with three queued writes: they must be dropped and the sweep restarts.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 8'(8'hC0 + i), 1'b1, 5'd20, 5'd22);
      #1;
      step();
    end
    drive(1'b0, 5'd0, 8'h00, 1'b1, 5'd20, 5'd22);
    #1;
    chk("pre_reset_pending", 32'(pending), 3);
    running = 1'b0;
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_reset_outputs();
    reset = 1'b0;
    drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd20, 5'd22);
    check_init_sweep();
    running = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
